spi_master: RTL and testbench
=============================

// Module: spi_master
// PURPOSE
//  Single-clock SPI master. Serialises one DATAWIDTH-bit word on MOSI, MSB first,
//  and captures a word from MISO at the same time. Supports SPI modes 0-3.
//  Uses a valid/ready handshake on the parallel side and has no chip-select output.
//  Sits between a bus-side controller and an external SPI slave; chip-select is owned upstream.
// PARAMETERS
//  SPI_MODE           0  SPI mode: CPOL = SPI_MODE[1], CPHA = SPI_MODE[0]
//  CLKS_PER_HALF_BIT  2  i_clk cycles per SCLK half-period (legal values >= 2)
//  DATAWIDTH          8  bits per transfer
// PORTS
//  i_clk       in   1          system clock; all logic on posedge
//  i_reset     in   1          asynchronous, active-high reset
//  i_tx_data   in   DATAWIDTH  word to transmit; sampled when the transfer is accepted
//  i_tx_valid  in   1          request to start a transfer
//  o_tx_ready  out  1          high = idle and able to accept a transfer
//  o_rx_valid  out  1          one-cycle pulse: o_rx_data holds a new word
//  o_rx_data   out  DATAWIDTH  last received word, MSB first on the wire
//  o_spi_clk   out  1          SCLK
//  i_spi_MISO  in   1          serial data from the slave
//  o_spi_MOSI  out  1          serial data to the slave
// BEHAVIOUR
//  Reset (asynchronous):
//  - o_tx_ready=0, o_rx_valid=0, o_rx_data=0, o_spi_MOSI=0, o_spi_clk=CPOL.
//  - Counters clear and the FSM goes to IDLE.
//  - o_tx_ready rises on the first posedge after i_reset falls.
//  - Asserting reset mid-transfer aborts the transfer and discards partial data.
//  FSM IDLE -> XFER -> IDLE:
//  - IDLE: o_tx_ready=1 and o_spi_clk=CPOL.
//  - Accept: at posedge T with i_tx_valid && o_tx_ready, latch i_tx_data, set o_tx_ready=0,
//    enter XFER.
//  - XFER: generate exactly 2*DATAWIDTH SCLK edges, one every CLKS_PER_HALF_BIT cycles.
//    Edge k (k = 1..2*DATAWIDTH) occurs at T + k*CLKS_PER_HALF_BIT.
//    Odd edges are leading edges; even edges are trailing edges.
//  - i_tx_valid and i_tx_data are ignored while in XFER.
//  MOSI:
//  - CPHA=0: bit DATAWIDTH-1 is driven at T+1; the next bit is driven on each trailing edge
//    except the last.
//  - CPHA=1: the next bit is driven on each leading edge, starting with the MSB on edge 1.
//  - After the transfer, MOSI holds its last value.
//  MISO:
//  - CPHA=0: sampled on leading edges. CPHA=1: sampled on trailing edges.
//  - Sampled in the same posedge that toggles SCLK.
//  - Shifted into the LSB of the receive shift register; the first sampled bit ends up as the MSB.
//  Completion:
//  - At T + 2*DATAWIDTH*CLKS_PER_HALF_BIT + 1 (33 cycles with defaults):
//    o_rx_data is updated, o_rx_valid is high for exactly one cycle, o_tx_ready returns to 1,
//    and SCLK rests at CPOL.
//  - o_rx_data holds its value until the next completion.
//  - If i_tx_valid stays high, the next transfer is accepted on the first ready cycle
//    (back-to-back, no gap beyond that one cycle).
//  Widths: no arithmetic beyond edge and bit counters.
//  - Edge counter width: clog2(2*DATAWIDTH+1). Half-bit counter width: clog2(CLKS_PER_HALF_BIT).
// TESTING
//  - Reset: hold i_reset high 10 cycles -> o_spi_clk=CPOL, o_tx_ready=0, o_rx_valid=0,
//    o_rx_data=0; o_tx_ready=1 one cycle after release.
//  - Mode 0, i_tx_data=8'hAB with a loopback slave returning 8'h5C:
//    MOSI bit sequence 1,0,1,0,1,0,1,1 on rising edges, 16 SCLK edges in total;
//    o_rx_data=8'h5C with a single o_rx_valid pulse 33 cycles after acceptance.
//  - Modes 1, 2, 3 with the same data:
//    idle SCLK = CPOL, MOSI changes on the correct edge, o_rx_data=8'h5C.
//  - i_tx_valid held high for 16 cycles with random MISO and i_tx_data=8'hAB:
//    exactly one transfer is accepted in that window and data changes during XFER are ignored;
//    a second transfer starts immediately after the first completes.
//  - Reset asserted at edge 7: outputs return to reset values at once;
//    a fresh 8'hAB transfer afterwards completes correctly.
//  - CLKS_PER_HALF_BIT=4, DATAWIDTH=16:
//    SCLK half-period is 4 cycles, 32 edges, o_rx_valid at T+129.

Source files
------------

// File: rtl/spi_master.sv
// SPI master: one DATAWIDTH-bit full-duplex transfer per accepted request,
// MSB first, SPI modes 0-3, valid/ready on the parallel side, no chip-select.
module spi_master #(
  parameter int SPI_MODE          = 0,
  parameter int CLKS_PER_HALF_BIT = 2,
  parameter int DATAWIDTH         = 8
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATAWIDTH-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_rx_valid,
  output logic [DATAWIDTH-1:0] o_rx_data,
  output logic                 o_spi_clk,
  input  logic                 i_spi_MISO,
  output logic                 o_spi_MOSI
);

  localparam logic CPOL = 1'((SPI_MODE >> 1) & 1);
  localparam logic CPHA = 1'(SPI_MODE & 1);

  localparam int unsigned HALF_W = (CLKS_PER_HALF_BIT > 1) ? $clog2(CLKS_PER_HALF_BIT) : 1;
  localparam int unsigned EDGE_W = $clog2(2 * DATAWIDTH + 1);

  localparam logic [HALF_W-1:0] HALF_LAST  = HALF_W'(CLKS_PER_HALF_BIT - 1);
  localparam logic [EDGE_W-1:0] EDGE_TOTAL = EDGE_W'(2 * DATAWIDTH);
  localparam logic [EDGE_W-1:0] EDGE_LAST  = EDGE_W'(2 * DATAWIDTH - 1);

  typedef enum logic {
    IDLE,
    XFER
  } state_t;

  state_t state, state_next;

  logic [HALF_W-1:0]    half_cnt;
  logic [EDGE_W-1:0]    edge_cnt;
  logic [DATAWIDTH-1:0] tx_shift;
  logic [DATAWIDTH-1:0] rx_shift;

  logic accept;
  logic done;
  logic sclk_edge;
  logic leading;
  logic last_edge;
  logic first_cycle;
  logic drive_mosi;
  logic sample_miso;

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and per-cycle strobes: accept, completion, SCLK edge and its kind.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    done        = 1'b0;
    sclk_edge   = 1'b0;
    leading     = 1'b0;
    last_edge   = 1'b0;
    first_cycle = 1'b0;
    case (state)
      IDLE: begin
        if (i_tx_valid && o_tx_ready) begin
          accept     = 1'b1;
          state_next = XFER;
        end
      end
      XFER: begin
        first_cycle = (edge_cnt == '0) && (half_cnt == '0);
        if (edge_cnt == EDGE_TOTAL) begin
          done       = 1'b1;
          state_next = IDLE;
        end else if (half_cnt == HALF_LAST) begin
          sclk_edge = 1'b1;
          // edge_cnt counts edges already produced, so an even count means the
          // edge being produced now is odd-numbered, i.e. a leading edge
          leading   = ~edge_cnt[0];
          last_edge = (edge_cnt == EDGE_LAST);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // CPHA=0 launches the MSB in the first XFER cycle and later bits on trailing
  // edges (the final trailing edge launches nothing); CPHA=1 launches on leading edges.
  always_comb begin
    drive_mosi  = 1'b0;
    sample_miso = 1'b0;
    if (CPHA) begin
      drive_mosi = sclk_edge && leading;
    end else begin
      drive_mosi = first_cycle || (sclk_edge && !leading && !last_edge);
    end
    sample_miso = sclk_edge && (leading != CPHA);
  end

  // Datapath: counters, SCLK, shift registers and handshake outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      half_cnt   <= '0;
      edge_cnt   <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      o_tx_ready <= 1'b0;
      o_rx_valid <= 1'b0;
      o_rx_data  <= '0;
      o_spi_MOSI <= 1'b0;
      o_spi_clk  <= CPOL;
    end else begin
      o_rx_valid <= 1'b0;
      if (accept) begin
        tx_shift   <= i_tx_data;
        rx_shift   <= '0;
        half_cnt   <= '0;
        edge_cnt   <= '0;
        o_tx_ready <= 1'b0;
      end else if (done) begin
        o_rx_data  <= rx_shift;
        o_rx_valid <= 1'b1;
        o_tx_ready <= 1'b1;
        o_spi_clk  <= CPOL;
      end else if (state == IDLE) begin
        o_tx_ready <= 1'b1;
      end else if (sclk_edge) begin
        half_cnt  <= '0;
        edge_cnt  <= edge_cnt + 1'b1;
        o_spi_clk <= ~o_spi_clk;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end

      if (drive_mosi) begin
        o_spi_MOSI <= tx_shift[DATAWIDTH-1];
        tx_shift   <= tx_shift << 1;
      end

      if (sample_miso) begin
        rx_shift <= {rx_shift[DATAWIDTH-2:0], i_spi_MISO};
      end
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: four 8-bit instances in modes 0-3 and one 16-bit,
// 4-cycle half-bit instance, each paired with a behavioural SPI slave.
module tb_spi_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  logic [15:0] tx_data    [5];
  logic        tx_valid   [5];
  logic        tx_ready   [5];
  logic        rx_valid   [5];
  logic [15:0] rx_data    [5];
  logic        spi_clk    [5];
  logic        mosi       [5];
  logic [15:0] slave_word [5];
  logic [15:0] st_in      [5];
  int          st_edges   [5];
  int          st_bad     [5];
  int          st_gap     [5];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    localparam int W      = (g == 4) ? 16 : 8;
    localparam int C      = (g == 4) ? 4 : 2;
    localparam int MODE   = (g == 4) ? 0 : g;
    localparam bit S_CPHA = (MODE % 2) == 1;

    logic [W-1:0] rxd;
    logic [W-1:0] s_out;
    logic [W-1:0] s_in;
    logic         miso;
    logic         s_prev_clk;
    logic         s_prev_mosi;
    int           s_edges, s_bad, s_gap, s_last;

    spi_master #(
      .SPI_MODE(MODE),
      .CLKS_PER_HALF_BIT(C),
      .DATAWIDTH(W)
    ) u_dut (
      .i_clk(clk),
      .i_reset(rst),
      .i_tx_data(tx_data[g][W-1:0]),
      .i_tx_valid(tx_valid[g]),
      .o_tx_ready(tx_ready[g]),
      .o_rx_valid(rx_valid[g]),
      .o_rx_data(rxd),
      .o_spi_clk(spi_clk[g]),
      .i_spi_MISO(miso),
      .o_spi_MOSI(mosi[g])
    );

    assign rx_data[g]  = 16'(rxd);
    assign st_in[g]    = 16'(s_in);
    assign st_edges[g] = s_edges;
    assign st_bad[g]   = s_bad;
    assign st_gap[g]   = s_gap;

    // Slave: captures MOSI on its sampling edges, launches MISO on the others,
    // and records edge count, edge spacing and MOSI changes on sampling edges.
    always @(negedge clk) begin
      if (rst || tx_ready[g]) begin
        s_out   = slave_word[g][W-1:0];
        s_in    = '0;
        s_edges = 0;
        s_bad   = 0;
        s_gap   = 0;
        s_last  = cyc;
      end else if (spi_clk[g] != s_prev_clk) begin
        s_edges++;
        if (s_edges > 1 && (cyc - s_last) != C) s_gap++;
        s_last = cyc;
        if (((s_edges % 2) == 1) != S_CPHA) begin
          s_in = {s_in[W-2:0], mosi[g]};
          if (mosi[g] != s_prev_mosi) s_bad++;
        end else if (!(!S_CPHA && s_edges == 2 * W) && !(S_CPHA && s_edges == 1)) begin
          s_out = s_out << 1;
        end
      end
      miso        = s_out[W-1];
      s_prev_clk  = spi_clk[g];
      s_prev_mosi = mosi[g];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic cpol_of(input int g);
    return (g == 2 || g == 3);
  endfunction

  // Wait (bounded) for the completion pulse; latency counted from acceptance.
  task automatic wait_done(input int g, input int t0, output int lat);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      if (rx_valid[g]) begin
        lat = cyc - t0;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic run_xfer(input int g, input logic [15:0] tx, input logic [15:0] sw,
                          input int exp_lat, input int exp_edges);
    int t0, lat;
    slave_word[g] = sw;
    @(negedge clk);
    check("idle_ready", tx_ready[g], 1'b1);
    check("idle_sclk", spi_clk[g], cpol_of(g));
    tx_data[g]  = tx;
    tx_valid[g] = 1'b1;
    @(posedge clk); #1;
    t0          = cyc;
    tx_valid[g] = 1'b0;
    tx_data[g]  = ~tx;
    check("accept_ready_low", tx_ready[g], 1'b0);
    wait_done(g, t0, lat);
    check("latency", lat, exp_lat);
    check("rx_data", rx_data[g], sw);
    check("mosi_bits", st_in[g], tx);
    check("edges", st_edges[g], exp_edges);
    check("mosi_edge", st_bad[g], 0);
    check("half_period", st_gap[g], 0);
    check("done_sclk", spi_clk[g], cpol_of(g));
    check("done_ready", tx_ready[g], 1'b1);
    @(posedge clk); #1;
    check("rx_valid_pulse", rx_valid[g], 1'b0);
    check("rx_data_hold", rx_data[g], sw);
  endtask

  initial begin
    int t0, lat, acc;
    logic [15:0] r1, r2;

    for (int i = 0; i < 5; i++) begin
      tx_data[i]    = '0;
      tx_valid[i]   = 1'b0;
      slave_word[i] = '0;
    end

    // Reset held for 10 cycles.
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    for (int g = 0; g < 5; g++) begin
      check("rst_sclk", spi_clk[g], cpol_of(g));
      check("rst_ready", tx_ready[g], 1'b0);
      check("rst_rx_valid", rx_valid[g], 1'b0);
      check("rst_rx_data", rx_data[g], 16'h0000);
      check("rst_mosi", mosi[g], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    for (int g = 0; g < 5; g++) check("ready_after_rst", tx_ready[g], 1'b1);

    // Modes 0-3, 0xAB out, slave returns 0x5C.
    for (int g = 0; g < 4; g++) run_xfer(g, 16'h00AB, 16'h005C, 33, 16);

    // Valid held for 16 cycles with changing data: one acceptance, then back-to-back.
    r1 = 16'($urandom_range(0, 255));
    r2 = 16'($urandom_range(1, 255));
    slave_word[0] = r1;
    @(negedge clk);
    tx_data[0]  = 16'h00AB;
    tx_valid[0] = 1'b1;
    acc = 0;
    t0  = 0;
    for (int i = 0; i < 16; i++) begin
      if (tx_valid[0] && tx_ready[0]) acc++;
      @(posedge clk); #1;
      if (i == 0) t0 = cyc;
      tx_data[0] = 16'($urandom_range(0, 255));
      @(negedge clk);
    end
    check("b2b_one_accept", acc, 1);
    tx_data[0] = 16'h0096;
    @(posedge clk); #1;
    wait_done(0, t0, lat);
    check("b2b_lat1", lat, 33);
    check("b2b_rx1", rx_data[0], r1);
    check("b2b_mosi1", st_in[0], 16'h00AB);
    slave_word[0] = r2;
    @(posedge clk); #1;
    t0 = cyc;
    check("b2b_second_accept", tx_ready[0], 1'b0);
    tx_valid[0] = 1'b0;
    wait_done(0, t0, lat);
    check("b2b_lat2", lat, 33);
    check("b2b_rx2", rx_data[0], r2);
    check("b2b_mosi2", st_in[0], 16'h0096);

    // Reset at SCLK edge 7 aborts the transfer.
    slave_word[0] = 16'h005C;
    @(negedge clk);
    tx_data[0]  = 16'h00AB;
    tx_valid[0] = 1'b1;
    @(posedge clk); #1;
    t0 = cyc;
    tx_valid[0] = 1'b0;
    for (int i = 0; i < 100 && (cyc - t0) < 14; i++) begin
      @(posedge clk); #1;
    end
    check("edge7_sclk_high", spi_clk[0], 1'b1);
    rst = 1'b1;
    #1;
    check("abort_sclk", spi_clk[0], 1'b0);
    check("abort_ready", tx_ready[0], 1'b0);
    check("abort_rx_valid", rx_valid[0], 1'b0);
    check("abort_rx_data", rx_data[0], 16'h0000);
    check("abort_mosi", mosi[0], 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_ready_back", tx_ready[0], 1'b1);
    run_xfer(0, 16'h00AB, 16'h005C, 33, 16);

    // 16-bit word, 4-cycle half period.
    run_xfer(4, 16'hA5C3, 16'h5C3A, 129, 32);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
